multdiv_unit: RTL

Multi-cycle signed 32-bit multiplier/divider in the execute stage, alongside the bitwise/arithmetic ALU. It takes the same operand pair the ALU receives from the ID/EX latch and produces a 32-bit result plus an exception flag. That result is muxed with the ALU result into the EX/MEM latch. The pipeline stalls on `busy` until `data_resultRDY`.

---
 rtl/multdiv_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// multdiv_unit -- multi-cycle signed 32-bit multiplier / divider for the execute stage.
//
// Multiply: the operand magnitudes are multiplied with unsigned shift-add, one partial
// product per cycle, into a 64-bit accumulator. The product is negated if the operand
// signs differ. Divide: restoring division on the magnitudes, one quotient bit per cycle.
// The quotient is negated if the signs differ and truncates toward zero.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous, active-low reset
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       start a multiply (takes priority over ctrl_DIV)
//   ctrl_DIV        start a divide
//   data_result     low 32 bits of the product, or the quotient (held until next completion)
//   data_exception  multiply overflow, divide by zero, or INT_MIN / -1
//   data_resultRDY  one-cycle pulse when data_result is valid
//   busy            operation in progress; starts are ignored while set
module multdiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      acc;      // product magnitude accumulator
    logic [63:0]      mcand;    // |A|, shifted left one place per iteration
    logic [31:0]      mplier;   // |B|, shifted right one place per iteration
    logic [32:0]      rem;      // partial remainder; 33 bits since it can reach 2*|B|-1
    logic [31:0]      quo;      // dividend bits shift out the top, quotient bits shift in
    logic [31:0]      divisor;
    logic             neg;      // operand signs differ
    logic             dz;       // divide by zero
    logic             ovf;      // INT_MIN / -1

    // |v| as an unsigned value; |0x80000000| = 0x80000000 fits in 32 unsigned bits.
    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        return v[31] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [63:0] apply_sign64(input logic [63:0] m, input logic n);
        return n ? -m : m;
    endfunction

    function automatic logic [31:0] apply_sign32(input logic [31:0] m, input logic n);
        return n ? -m : m;
    endfunction

    // The product fits in 32 signed bits only if the high word is the sign extension.
    function automatic logic mult_ovf(input logic [63:0] p);
        return p[63:32] != {32{p[31]}};
    endfunction

    logic [63:0] acc_nx;
    logic [63:0] prod;
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic        fits;
    logic [32:0] rem_nx;
    logic [31:0] quo_nx;

    always_comb begin
        acc_nx = acc + (mplier[0] ? mcand : 64'd0);
        prod   = apply_sign64(acc_nx, neg);
        rem_sh = {rem[31:0], quo[31]};
        diff   = {1'b0, rem_sh} - {2'b00, divisor};
        fits   = ~diff[33];
        rem_nx = fits ? diff[32:0] : rem_sh;
        quo_nx = {quo[30:0], fits};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            rem            <= '0;
            quo            <= '0;
            divisor        <= '0;
            neg            <= 1'b0;
            dz             <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                    cnt            <= '0;
                    neg            <= data_operandA[31] ^ data_operandB[31];
                    if (ctrl_MULT) begin
                        state  <= MULT;
                        busy   <= 1'b1;
                        acc    <= '0;
                        mcand  <= {32'd0, mag32(data_operandA)};
                        mplier <= mag32(data_operandB);
                    end else if (ctrl_DIV) begin
                        state   <= DIV;
                        busy    <= 1'b1;
                        rem     <= '0;
                        quo     <= mag32(data_operandA);
                        divisor <= mag32(data_operandB);
                        dz      <= (data_operandB == 32'd0);
                        ovf     <= (data_operandA == 32'h8000_0000) &&
                                   (data_operandB == 32'hFFFF_FFFF);
                    end
                end
                MULT: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        data_result    <= prod[31:0];
                        data_exception <= mult_ovf(prod);
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end
                end
                DIV: begin
                    // Zero divisor was flagged on the start edge; finish on the next
                    // edge without iterating.
                    if (dz) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            // INT_MIN / -1 yields magnitude 0x80000000 with matching
                            // signs, which is already the required wrapped result.
                            data_result    <= apply_sign32(quo_nx, neg);
                            data_exception <= ovf;
                            data_resultRDY <= 1'b1;
                            busy           <= 1'b0;
                            state          <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
